uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART TX channel between NUM_REQ requesters (e.g. CPU MMIO port, debug/trace source).
//  Round-robin arbitration picks a requester and captures its byte.
//  Drives the TX FSM's send strobe, then waits for the TX frame-done flag.
//  Enforces a programmable inter-frame gap; a watchdog recovers from a stuck transmitter.
// PARAMETERS
//  NUM_REQ        2      number of requesters (2..8)
//  IDX_W          1      owner index width, = clog2(NUM_REQ) (min 1)
//  GAP_CYCLES     16     idle clocks after each frame before re-arbitration (0 = no gap)
//  TIMEOUT_CYCLES 100000 max clocks in WAIT_DONE before forced abort (>=1)
// PORTS
//  i_clk       in   1          system clock, rising edge
//  i_rst       in   1          asynchronous reset, active-high
//  i_req       in   NUM_REQ    per-requester level request; hold with data until acked
//  i_data      in   8*NUM_REQ  byte of requester k on i_data[8k+7:8k]
//  o_ack       out  NUM_REQ    one-cycle pulse: requester k's byte captured
//  o_tx_send   out  1          one-cycle start strobe to UART TX FSM
//  o_tx_data   out  8          captured byte to TX data register
//  i_tx_done   in   1          TX frame-finished flag (level or pulse)
//  o_busy      out  1          high in every state except IDLE
//  o_owner     out  IDX_W      index of the current/last granted requester
//  o_timeout   out  1          one-cycle pulse when the watchdog aborts a frame
// BEHAVIOUR
//  Reset (async, i_rst=1): state=IDLE, rr pointer=0; all outputs 0.
//   Reset mid-frame abandons the frame silently; no ack/send after release until a new request.
//  States (3-bit encoded; outputs registered/decoded from state only; no combinational path from inputs):
//   IDLE      : if |i_req -> GRANT; winner = first set bit searching ptr, ptr+1, .. mod NUM_REQ
//               winner index and i_data slice registered on this edge
//   GRANT     : o_ack[owner]=1 for exactly this cycle -> SEND
//   SEND      : o_tx_send=1 for exactly this cycle -> WAIT_DONE; watchdog cleared
//   WAIT_DONE : i_tx_done=1 -> GAP
//               watchdog reaches TIMEOUT_CYCLES-1 -> ABORT
//               both in same cycle: i_tx_done wins (no timeout)
//   ABORT     : o_timeout=1 for one cycle -> GAP
//   GAP       : counter runs GAP_CYCLES clocks -> IDLE
//               GAP_CYCLES=0: GAP is one cycle then IDLE
//  Rotation: ptr <= owner+1, wrapping NUM_REQ-1 -> 0, updated on the IDLE->GRANT edge.
//   Result: continuous requests from all sources are served strictly in turn.
//  Latency: req seen at IDLE edge t -> o_ack high cycle t+1, o_tx_send high cycle t+2.
//  o_tx_data and o_owner are stable from GRANT through the return to IDLE; change only on next grant.
//  i_tx_done is sampled only in WAIT_DONE and ignored in every other state, including the SEND cycle.
//  i_req and i_data are sampled only in IDLE. Requester drops its req on the cycle after seeing ack.
//   A req still high when the arbiter re-enters IDLE counts as a new request.
//  i_req bits beyond NUM_REQ do not exist; unused IDX_W codes never produced.
//  o_busy=0 only in IDLE; a single idle cycle is guaranteed between frames.
// TESTING
//  1 Reset: i_rst pulse mid-WAIT_DONE -> all outputs 0 within same cycle;
//    no o_tx_send until new req; ptr back to 0.
//  2 Single req: i_req=2'b01, data0=8'hA5 -> o_ack=01 at t+1, o_tx_send at t+2, o_tx_data=A5;
//    i_tx_done after 50 clk -> GAP 16 clk -> o_busy=0.
//  3 Round robin: i_req=2'b11 held (re-raised after each ack), data0=11, data1=22
//    -> owners 0,1,0,1; o_tx_data 11,22,11,22.
//  4 Timeout: TIMEOUT_CYCLES=20, never assert i_tx_done -> o_timeout pulse 20 clk after SEND,
//    then GAP, then next pending req served.
//  5 Races: i_tx_done in SEND cycle -> ignored, still waits;
//    i_tx_done and watchdog expiry same cycle -> no o_timeout.
//  6 GAP_CYCLES=0, NUM_REQ=3, i_req=3'b101, ptr=1 -> requester 2 granted first,
//    then 0; one IDLE cycle between frames.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART TX channel with inter-frame gap and watchdog
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int IDX_W          = 1,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [8*NUM_REQ-1:0] i_data,
  output logic [NUM_REQ-1:0]   o_ack,
  output logic                 o_tx_send,
  output logic [7:0]           o_tx_data,
  input  logic                 i_tx_done,
  output logic                 o_busy,
  output logic [IDX_W-1:0]     o_owner,
  output logic                 o_timeout
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GP_W = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GP_W-1:0] GP_LAST = GP_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_SEND, S_WAIT, S_ABORT, S_GAP} state_t;
  state_t              r_state;
  logic [IDX_W-1:0]    r_ptr, r_owner;
  logic [7:0]          r_data;
  logic [NUM_REQ-1:0]  r_ack;
  logic                r_send, r_timeout;
  logic [WD_W-1:0]     r_wd;
  logic [GP_W-1:0]     r_gap;
  logic [NUM_REQ-1:0]  w_rot;
  logic [IDX_W-1:0]    w_off, w_win, w_nptr;
  logic [IDX_W:0]      w_sum;
  logic [7:0]          w_byte;
  // Rotate requests so bit 0 is the requester at the pointer; lowest set bit wins.
  assign w_rot = NUM_REQ'({i_req, i_req} >> r_ptr);
  always_comb begin
    w_off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (w_rot[i]) w_off = IDX_W'(i);
  end
  assign w_sum  = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_win  = (w_sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ)) : w_sum[IDX_W-1:0];
  assign w_nptr = (w_win == IDX_W'(NUM_REQ - 1)) ? '0 : w_win + IDX_W'(1);
  always_comb begin
    w_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) if (w_win == IDX_W'(i)) w_byte = i_data[8*i +: 8];
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_data    <= '0;
      r_ack     <= '0;
      r_send    <= 1'b0;
      r_timeout <= 1'b0;
      r_wd      <= '0;
      r_gap     <= '0;
    end else begin
      r_ack     <= '0;
      r_send    <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: if (|i_req) begin
          r_state <= S_GRANT;
          r_owner <= w_win;
          r_data  <= w_byte;
          r_ptr   <= w_nptr;
          r_ack   <= NUM_REQ'(1) << w_win;
        end
        S_GRANT: begin
          r_state <= S_SEND;
          r_send  <= 1'b1;
        end
        S_SEND: begin
          r_state <= S_WAIT;
          r_wd    <= '0;
        end
        S_WAIT: if (i_tx_done) begin
          r_state <= S_GAP;
          r_gap   <= '0;
        end else if (r_wd == WD_LAST) begin
          r_state   <= S_ABORT;
          r_timeout <= 1'b1;
        end else r_wd <= r_wd + WD_W'(1);
        S_ABORT: begin
          r_state <= S_GAP;
          r_gap   <= '0;
        end
        S_GAP: if (r_gap == GP_LAST) r_state <= S_IDLE;
          else r_gap <= r_gap + GP_W'(1);
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign o_ack     = r_ack;
  assign o_tx_send = r_send;
  assign o_tx_data = r_data;
  assign o_owner   = r_owner;
  assign o_timeout = r_timeout;
  assign o_busy    = r_state != S_IDLE;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of arbitration, latency, gap, watchdog and reset
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;

  logic [1:0]  a_req = '0, a_ack;
  logic [15:0] a_data = '0;
  logic        a_send, a_done = 1'b0, a_busy, a_to;
  logic [7:0]  a_txd;
  logic [0:0]  a_own;

  logic [1:0]  b_req = '0, b_ack;
  logic [15:0] b_data = '0;
  logic        b_send, b_done = 1'b0, b_busy, b_to;
  logic [7:0]  b_txd;
  logic [0:0]  b_own;

  logic [2:0]  c_req = '0, c_ack;
  logic [23:0] c_data = '0;
  logic        c_send, c_done = 1'b0, c_busy, c_to;
  logic [7:0]  c_txd;
  logic [1:0]  c_own;

  uart_tx_arbiter dut_a (
    .i_clk(clk), .i_rst(rst), .i_req(a_req), .i_data(a_data), .o_ack(a_ack),
    .o_tx_send(a_send), .o_tx_data(a_txd), .i_tx_done(a_done), .o_busy(a_busy),
    .o_owner(a_own), .o_timeout(a_to));

  uart_tx_arbiter #(.NUM_REQ(2), .IDX_W(1), .GAP_CYCLES(4), .TIMEOUT_CYCLES(20)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_req(b_req), .i_data(b_data), .o_ack(b_ack),
    .o_tx_send(b_send), .o_tx_data(b_txd), .i_tx_done(b_done), .o_busy(b_busy),
    .o_owner(b_own), .o_timeout(b_to));

  uart_tx_arbiter #(.NUM_REQ(3), .IDX_W(2), .GAP_CYCLES(0), .TIMEOUT_CYCLES(100)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_req(c_req), .i_data(c_data), .o_ack(c_ack),
    .o_tx_send(c_send), .o_tx_data(c_txd), .i_tx_done(c_done), .o_busy(c_busy),
    .o_owner(c_own), .o_timeout(c_to));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a_idle(input int lim);
    int n = 0;
    while (a_busy && n < lim) begin tick(); n++; end
    checks++;
    if (a_busy !== 1'b0) begin errors++; $display("FAIL a_idle_wait busy=%b want 0 after %0d cycles", a_busy, n); end
  endtask

  task automatic wait_b_idle(input int lim);
    int n = 0;
    while (b_busy && n < lim) begin tick(); n++; end
    checks++;
    if (b_busy !== 1'b0) begin errors++; $display("FAIL b_idle_wait busy=%b want 0 after %0d cycles", b_busy, n); end
  endtask

  task automatic test_reset;
    int sends;
    tick();
    checks++;
    if ({a_ack, a_send, a_txd, a_busy, a_own, a_to} !== 14'd0 ||
        {b_ack, b_send, b_txd, b_busy, b_own, b_to} !== 14'd0 ||
        {c_ack, c_send, c_txd, c_busy, c_own, c_to} !== 16'd0)
      begin errors++; $display("FAIL reset_outputs a=%h b=%h c=%h want 0", {a_ack, a_send, a_txd, a_busy, a_own, a_to},
                               {b_ack, b_send, b_txd, b_busy, b_own, b_to}, {c_ack, c_send, c_txd, c_busy, c_own, c_to}); end
    rst = 1'b0;
    tick();
    a_data = 16'h7766;
    a_req = 2'b01;
    tick();
    a_req = 2'b00;
    tick();
    tick();
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({a_ack, a_send, a_txd, a_busy, a_own, a_to} !== 14'd0)
      begin errors++; $display("FAIL reset_midframe got=%h want 0", {a_ack, a_send, a_txd, a_busy, a_own, a_to}); end
    tick();
    rst = 1'b0;
    sends = 0;
    for (int i = 0; i < 6; i++) begin
      a_done = (i == 2);
      tick();
      sends += (a_send || a_busy || a_ack != 0) ? 1 : 0;
    end
    a_done = 1'b0;
    checks++;
    if (sends !== 0) begin errors++; $display("FAIL reset_no_activity active_cycles=%0d want 0", sends); end
  endtask

  task automatic test_round_robin;
    int n;
    logic [1:0] exp_ack;
    logic [7:0] exp_d;
    a_data = {8'h22, 8'h11};
    a_req = 2'b11;
    for (int f = 0; f < 4; f++) begin
      exp_ack = 2'b01 << (f % 2);
      exp_d = (f % 2) ? 8'h22 : 8'h11;
      n = 0;
      tick();
      while (a_ack == 2'b00 && n < 40) begin tick(); n++; end
      checks++;
      if (a_ack !== exp_ack) begin errors++; $display("FAIL rr_ack frame=%0d got=%b want %b", f, a_ack, exp_ack); end
      a_req = a_req & ~exp_ack;
      tick();
      checks++;
      if (a_send !== 1'b1 || a_own !== 1'(f % 2) || a_txd !== exp_d)
        begin errors++; $display("FAIL rr_send frame=%0d send=%b owner=%0d data=%h want 1/%0d/%h", f, a_send, a_own, a_txd, f % 2, exp_d); end
      a_req = (f == 3) ? 2'b00 : (a_req | exp_ack);
      tick();
      tick();
      tick();
      a_done = 1'b1;
      tick();
      a_done = 1'b0;
      wait_a_idle(30);
    end
  endtask

  task automatic test_single;
    a_data = 16'h00A5;
    a_req = 2'b01;
    tick();
    checks++;
    if (a_ack !== 2'b01 || a_send !== 1'b0) begin errors++; $display("FAIL single_ack ack=%b send=%b want 01/0", a_ack, a_send); end
    a_req = 2'b00;
    tick();
    checks++;
    if (a_send !== 1'b1 || a_txd !== 8'hA5 || a_ack !== 2'b00)
      begin errors++; $display("FAIL single_send send=%b data=%h ack=%b want 1/a5/00", a_send, a_txd, a_ack); end
    a_data = 16'hFFFF;
    repeat (50) tick();
    checks++;
    if (a_busy !== 1'b1 || a_to !== 1'b0) begin errors++; $display("FAIL single_wait busy=%b timeout=%b want 1/0", a_busy, a_to); end
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    repeat (15) tick();
    checks++;
    if (a_busy !== 1'b1) begin errors++; $display("FAIL single_gap_end busy=%b want 1", a_busy); end
    tick();
    checks++;
    if (a_busy !== 1'b0 || a_txd !== 8'hA5 || a_own !== 1'b0)
      begin errors++; $display("FAIL single_idle busy=%b data=%h owner=%0d want 0/a5/0", a_busy, a_txd, a_own); end
  endtask

  task automatic test_timeout;
    b_data = {8'h5A, 8'h3C};
    b_req = 2'b11;
    tick();
    checks++;
    if (b_ack !== 2'b01) begin errors++; $display("FAIL to_ack0 got=%b want 01", b_ack); end
    b_req = 2'b10;
    tick();
    checks++;
    if (b_send !== 1'b1 || b_txd !== 8'h3C) begin errors++; $display("FAIL to_send0 send=%b data=%h want 1/3c", b_send, b_txd); end
    for (int n = 1; n <= 22; n++) begin
      tick();
      checks++;
      if (b_to !== (n == 21)) begin errors++; $display("FAIL to_pulse cycle=%0d got=%b want %b", n, b_to, n == 21); end
    end
    repeat (4) tick();
    checks++;
    if (b_busy !== 1'b0) begin errors++; $display("FAIL to_gap_idle busy=%b want 0", b_busy); end
    tick();
    checks++;
    if (b_ack !== 2'b10 || b_own !== 1'b1) begin errors++; $display("FAIL to_next_req ack=%b owner=%0d want 10/1", b_ack, b_own); end
    b_req = 2'b00;
  endtask

  task automatic test_races;
    tick();
    checks++;
    if (b_send !== 1'b1 || b_txd !== 8'h5A) begin errors++; $display("FAIL race_send1 send=%b data=%h want 1/5a", b_send, b_txd); end
    b_done = 1'b1;
    tick();
    b_done = 1'b0;
    for (int n = 2; n <= 21; n++) begin
      tick();
      checks++;
      if (b_to !== (n == 21)) begin errors++; $display("FAIL race_send_done cycle=%0d timeout=%b want %b", n, b_to, n == 21); end
    end
    wait_b_idle(20);
    b_req = 2'b01;
    tick();
    checks++;
    if (b_ack !== 2'b01) begin errors++; $display("FAIL race_ack2 got=%b want 01", b_ack); end
    b_req = 2'b00;
    tick();
    for (int n = 1; n <= 20; n++) begin
      tick();
      checks++;
      if (b_to !== 1'b0) begin errors++; $display("FAIL race_wait cycle=%0d timeout=%b want 0", n, b_to); end
    end
    b_done = 1'b1;
    tick();
    b_done = 1'b0;
    checks++;
    if (b_to !== 1'b0 || b_busy !== 1'b1) begin errors++; $display("FAIL race_tie timeout=%b busy=%b want 0/1", b_to, b_busy); end
    tick();
    checks++;
    if (b_to !== 1'b0) begin errors++; $display("FAIL race_tie_after timeout=%b want 0", b_to); end
    wait_b_idle(20);
  endtask

  task automatic test_gap0_three;
    c_data = {8'hC2, 8'hC1, 8'hC0};
    c_req = 3'b001;
    tick();
    checks++;
    if (c_ack !== 3'b001) begin errors++; $display("FAIL g0_prime_ack got=%b want 001", c_ack); end
    c_req = 3'b000;
    tick();
    tick();
    c_done = 1'b1;
    tick();
    c_done = 1'b0;
    checks++;
    if (c_busy !== 1'b1) begin errors++; $display("FAIL g0_gap busy=%b want 1", c_busy); end
    tick();
    checks++;
    if (c_busy !== 1'b0) begin errors++; $display("FAIL g0_gap_one busy=%b want 0", c_busy); end
    c_req = 3'b101;
    tick();
    checks++;
    if (c_ack !== 3'b100 || c_own !== 2'd2) begin errors++; $display("FAIL g0_first ack=%b owner=%0d want 100/2", c_ack, c_own); end
    c_req = 3'b001;
    tick();
    checks++;
    if (c_send !== 1'b1 || c_txd !== 8'hC2) begin errors++; $display("FAIL g0_send2 send=%b data=%h want 1/c2", c_send, c_txd); end
    tick();
    c_done = 1'b1;
    tick();
    c_done = 1'b0;
    tick();
    checks++;
    if (c_busy !== 1'b0 || c_ack !== 3'b000) begin errors++; $display("FAIL g0_idle busy=%b ack=%b want 0/000", c_busy, c_ack); end
    tick();
    checks++;
    if (c_ack !== 3'b001 || c_own !== 2'd0) begin errors++; $display("FAIL g0_second ack=%b owner=%0d want 001/0", c_ack, c_own); end
    c_req = 3'b000;
    tick();
    checks++;
    if (c_send !== 1'b1 || c_txd !== 8'hC0) begin errors++; $display("FAIL g0_send0 send=%b data=%h want 1/c0", c_send, c_txd); end
    tick();
    c_done = 1'b1;
    tick();
    c_done = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_timeout();
    test_races();
    test_gap0_three();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout bench did not complete within time limit");
    $fatal(1, "simulation time limit");
  end
endmodule
